// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch front-end: RV32I control-flow opcodes,
// fetch FSM encoding, instruction-queue entry layout and J-immediate decode.
package fetch_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
    localparam logic [1:0] ST_DROP  = 2'd3;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } iq_entry_t;

    // J-type immediate: sign-extended, bit 0 always zero.
    function automatic logic [31:0] j_imm(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/instruction_fetcher_if.sv
// Fetch-stage bus bundle: icache request/response, RoB redirect and the
// issue handshake towards the decoder/dispatcher.
interface instruction_fetcher_if;

    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_inst;
    logic        flush_in;
    logic [31:0] flush_pc;
    logic        issue_valid;
    logic [31:0] issue_inst;
    logic [31:0] issue_pc;
    logic        issue_pred_taken;
    logic        issue_ready;

    modport master (
        output icache_req_valid, icache_req_addr,
        input  icache_resp_valid, icache_resp_inst,
        input  flush_in, flush_pc,
        output issue_valid, issue_inst, issue_pc, issue_pred_taken,
        input  issue_ready
    );

    modport slave (
        input  icache_req_valid, icache_req_addr,
        output icache_resp_valid, icache_resp_inst,
        output flush_in, flush_pc,
        input  issue_valid, issue_inst, issue_pc, issue_pred_taken,
        output issue_ready
    );

endinterface

// File: rtl/inst_queue.sv
// Circular in-order instruction queue, depth 2**WIDTH, with synchronous clear.
// A push alongside a pop is accepted even when full.
module inst_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      push,
    input  iq_entry_t push_data,
    input  logic      pop,
    input  logic      clear,
    output logic      full,
    output logic      empty,
    output iq_entry_t head
);

    localparam int DEPTH = 1 << WIDTH;

    iq_entry_t        mem [DEPTH];
    logic [WIDTH-1:0] head_ptr;
    logic [WIDTH-1:0] tail_ptr;
    logic [WIDTH:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (WIDTH+1)'(DEPTH));
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;
    assign head    = mem[head_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) tail_ptr <= tail_ptr + 1'b1;
            if (do_pop)  head_ptr <= head_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: payload storage is not reset; count/pointers alone decide validity.
    always_ff @(posedge clk_in) begin
        if (do_push) mem[tail_ptr] <= push_data;
    end

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch stage: owns the fetch PC, issues one icache request at a time,
// statically predicts jal taken, stalls on jalr until a RoB flush.
module instruction_fetcher
    import fetch_pkg::*;
#(
    parameter int          IQ_WIDTH = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    instruction_fetcher_if.master bus
);

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        push_req;
    logic        pred;
    logic        q_full;
    logic        q_empty;
    logic        q_push;
    logic        q_pop;
    logic        q_clear;
    iq_entry_t   q_head;
    iq_entry_t   push_data;
    logic [6:0]  opcode;

    assign opcode    = bus.icache_resp_inst[6:0];
    assign push_data = '{inst: bus.icache_resp_inst, pc: pc, pred: pred};

    always_comb begin
        // NOTE: every signal gets a default first so no branch infers a latch.
        state_next = state;
        pc_next    = pc;
        push_req   = 1'b0;
        pred       = 1'b0;
        if (bus.flush_in) begin
            pc_next    = bus.flush_pc;
            state_next = (state == ST_WAIT && !bus.icache_resp_valid) ? ST_DROP : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (!q_full) state_next = ST_WAIT;
                ST_WAIT: begin
                    if (bus.icache_resp_valid) begin
                        push_req   = 1'b1;
                        pc_next    = pc + 32'd4;
                        state_next = ST_IDLE;
                        if (opcode == OP_JAL) begin
                            pc_next = pc + j_imm(bus.icache_resp_inst);
                            pred    = 1'b1;
                        end else if (opcode == OP_JALR) begin
                            state_next = ST_STALL;
                        end
                    end
                end
                ST_STALL: state_next = ST_STALL;
                ST_DROP:  if (bus.icache_resp_valid) state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
        end else if (rdy_in) begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Flush wins over any same-cycle push or pop.
    assign q_clear = rdy_in && bus.flush_in;
    assign q_push  = rdy_in && push_req;
    assign q_pop   = rdy_in && !bus.flush_in && !q_empty && bus.issue_ready;

    inst_queue #(.WIDTH(IQ_WIDTH)) u_queue (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (q_push),
        .push_data (push_data),
        .pop       (q_pop),
        .clear     (q_clear),
        .full      (q_full),
        .empty     (q_empty),
        .head      (q_head)
    );

    // Requests are suppressed on a flush cycle so no response goes unclaimed.
    assign bus.icache_req_valid = rdy_in && !rst_in && !bus.flush_in && (state == ST_IDLE) && !q_full;
    assign bus.icache_req_addr  = pc;

    assign bus.issue_valid      = !q_empty;
    assign bus.issue_inst       = q_empty ? 32'h0 : q_head.inst;
    assign bus.issue_pc         = q_empty ? 32'h0 : q_head.pc;
    assign bus.issue_pred_taken = !q_empty && q_head.pred;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher with a small in-bench icache model.
module tb_instruction_fetcher;

    logic clk;
    logic rst;
    logic rdy;

    instruction_fetcher_if bus ();

    instruction_fetcher #(.IQ_WIDTH(2), .RESET_PC(32'h0)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // icache model state
    logic [31:0] imem [logic [31:0]];
    int          lat;
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          cyc;

    logic [31:0] req_addr_q [$];
    int          req_cyc_q  [$];
    logic [31:0] pop_pc_q   [$];
    logic [31:0] pop_inst_q [$];
    logic        pop_pred_q [$];
    int          pop_cyc_q  [$];

    logic        s_req_valid;
    logic        s_issue_valid;
    logic [31:0] s_issue_pc;

    function automatic logic [31:0] fetch_word(input logic [31:0] a);
        if (imem.exists(a)) return imem[a];
        return 32'h00100093;
    endfunction

    task automatic clear_logs();
        req_addr_q.delete(); req_cyc_q.delete();
        pop_pc_q.delete(); pop_inst_q.delete(); pop_pred_q.delete(); pop_cyc_q.delete();
    endtask

    // Called at a negedge: applies inputs, samples, then waits for the next negedge.
    task automatic run_cycle(input logic fl, input logic [31:0] fpc);
        logic resp;
        resp = rdy && pend && (pend_cnt == 0);
        bus.icache_resp_valid = resp;
        bus.icache_resp_inst  = resp ? fetch_word(pend_addr) : 32'h0;
        bus.flush_in = fl;
        bus.flush_pc = fpc;
        #1;
        s_req_valid   = bus.icache_req_valid;
        s_issue_valid = bus.issue_valid;
        s_issue_pc    = bus.issue_pc;
        if (rdy && !fl && bus.issue_valid && bus.issue_ready) begin
            pop_pc_q.push_back(bus.issue_pc);
            pop_inst_q.push_back(bus.issue_inst);
            pop_pred_q.push_back(bus.issue_pred_taken);
            pop_cyc_q.push_back(cyc);
        end
        if (rdy) begin
            if (resp) pend = 1'b0;
            else if (pend) pend_cnt--;
        end
        if (bus.icache_req_valid) begin
            req_addr_q.push_back(bus.icache_req_addr);
            req_cyc_q.push_back(cyc);
            pend      = 1'b1;
            pend_addr = bus.icache_req_addr;
            pend_cnt  = lat - 1;
        end
        cyc++;
        @(negedge clk);
        bus.icache_resp_valid = 1'b0;
        bus.flush_in = 1'b0;
    endtask

    logic [31:0] exp_addr [6];
    logic        exp_pred [6];
    int          p0;
    int          fcyc;
    int          nreq;

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus.icache_resp_valid = 1'b0;
        bus.icache_resp_inst  = 32'h0;
        bus.flush_in    = 1'b0;
        bus.flush_pc    = 32'h0;
        bus.issue_ready = 1'b1;
        lat  = 1;
        pend = 1'b0;
        pend_addr = 32'h0;
        pend_cnt  = 0;
        cyc  = 0;
        imem[32'h8]  = 32'h0100006F;   // jal x0, +16
        imem[32'h20] = 32'h000080E7;   // jalr x1, 0(x1)

        repeat (2) @(negedge clk);
        check("rst_req_valid", bus.icache_req_valid, 0);
        check("rst_issue_valid", bus.issue_valid, 0);
        check("rst_issue_pc", bus.issue_pc, 0);
        check("rst_issue_inst", bus.issue_inst, 0);
        check("rst_issue_pred", bus.issue_pred_taken, 0);
        rst = 1'b0;

        // Sequential fetch, jal redirect, jalr stall
        exp_addr = '{32'h0, 32'h4, 32'h8, 32'h18, 32'h1C, 32'h20};
        exp_pred = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        repeat (13) run_cycle(1'b0, 32'h0);
        check("seq_req_count", req_addr_q.size(), 6);
        check("seq_pop_count", pop_pc_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < req_addr_q.size()) begin
                check($sformatf("seq_req_addr[%0d]", i), req_addr_q[i], exp_addr[i]);
                check($sformatf("seq_req_cyc[%0d]", i), req_cyc_q[i], 2 * i);
            end
            if (i < pop_pc_q.size()) begin
                check($sformatf("seq_pop_pc[%0d]", i), pop_pc_q[i], exp_addr[i]);
                check($sformatf("seq_pop_pred[%0d]", i), pop_pred_q[i], exp_pred[i]);
            end
        end
        if (pop_inst_q.size() > 2) check("jal_inst", pop_inst_q[2], 32'h0100006F);
        if (pop_inst_q.size() > 0) check("addi_inst", pop_inst_q[0], 32'h00100093);

        repeat (10) run_cycle(1'b0, 32'h0);
        check("jalr_stall_no_req", req_addr_q.size(), 6);

        // Flush out of STALL; hold issue_ready low to fill the queue
        clear_logs();
        bus.issue_ready = 1'b0;
        fcyc = cyc;
        run_cycle(1'b1, 32'h100);
        repeat (20) run_cycle(1'b0, 32'h0);
        check("fill_req_count", req_addr_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < req_addr_q.size())
                check($sformatf("fill_req_addr[%0d]", i), req_addr_q[i], 32'h100 + 4 * i);
        if (req_cyc_q.size() > 0) check("flush_req_cyc", req_cyc_q[0], fcyc + 1);
        check("full_req_valid", s_req_valid, 0);
        check("full_issue_valid", s_issue_valid, 1);
        check("full_head_pc", s_issue_pc, 32'h100);

        // One pop frees one slot: exactly one request, the next cycle
        bus.issue_ready = 1'b1;
        p0 = cyc;
        run_cycle(1'b0, 32'h0);
        bus.issue_ready = 1'b0;
        repeat (10) run_cycle(1'b0, 32'h0);
        check("refill_req_count", req_addr_q.size(), 5);
        if (req_addr_q.size() > 4) begin
            check("refill_req_addr", req_addr_q[4], 32'h110);
            check("refill_req_cyc", req_cyc_q[4], p0 + 1);
        end
        check("refill_head_pc", s_issue_pc, 32'h104);

        // Flush while WAIT; orphan response arrives 3 cycles later
        clear_logs();
        lat = 4;
        fcyc = cyc;
        run_cycle(1'b1, 32'h200);
        bus.issue_ready = 1'b1;
        run_cycle(1'b0, 32'h0);
        run_cycle(1'b1, 32'h300);
        repeat (10) run_cycle(1'b0, 32'h0);
        if (req_addr_q.size() >= 2) begin
            check("drop_req0_addr", req_addr_q[0], 32'h200);
            check("drop_req0_cyc", req_cyc_q[0], fcyc + 1);
            check("drop_req1_addr", req_addr_q[1], 32'h300);
            check("drop_req1_cyc", req_cyc_q[1], fcyc + 6);
        end else check("drop_req_count", req_addr_q.size(), 2);
        if (pop_pc_q.size() >= 1) begin
            check("drop_first_pop_pc", pop_pc_q[0], 32'h300);
            check("drop_first_pop_cyc", pop_cyc_q[0], fcyc + 11);
        end else check("drop_pop_count", pop_pc_q.size(), 1);

        // Flush coincident with a response and a pop
        bus.issue_ready = 1'b0;
        lat = 1;
        repeat (25) run_cycle(1'b0, 32'h0);
        clear_logs();
        bus.issue_ready = 1'b1;
        p0 = cyc;
        run_cycle(1'b0, 32'h0);
        run_cycle(1'b0, 32'h0);
        run_cycle(1'b1, 32'h400);
        run_cycle(1'b0, 32'h0);
        check("coinc_issue_valid", s_issue_valid, 0);
        if (req_addr_q.size() >= 2) begin
            check("coinc_req_addr", req_addr_q[1], 32'h400);
            check("coinc_req_cyc", req_cyc_q[1], p0 + 3);
        end else check("coinc_req_count", req_addr_q.size(), 2);
        run_cycle(1'b0, 32'h0);
        run_cycle(1'b0, 32'h0);
        check("coinc_pop_count", pop_pc_q.size(), 3);
        if (pop_pc_q.size() >= 3) begin
            check("coinc_pop0_pc", pop_pc_q[0], 32'h304);
            check("coinc_pop1_pc", pop_pc_q[1], 32'h308);
            check("coinc_pop2_pc", pop_pc_q[2], 32'h400);
            check("coinc_pop2_cyc", pop_cyc_q[2], p0 + 5);
        end

        // rdy_in low freezes everything
        nreq = req_addr_q.size();
        rdy = 1'b0;
        repeat (3) run_cycle(1'b0, 32'h0);
        check("rdy_low_req_valid", s_req_valid, 0);
        check("rdy_low_req_count", req_addr_q.size(), nreq);
        rdy = 1'b1;
        run_cycle(1'b0, 32'h0);
        run_cycle(1'b0, 32'h0);
        if (pop_pc_q.size() >= 4) check("rdy_resume_pop_pc", pop_pc_q[3], 32'h404);
        else check("rdy_resume_pop_count", pop_pc_q.size(), 4);

        // Reset mid-operation
        rst = 1'b1;
        #1;
        check("midrst_req_valid", bus.icache_req_valid, 0);
        check("midrst_issue_valid", bus.issue_valid, 0);
        @(negedge clk);
        pend = 1'b0;
        clear_logs();
        rst = 1'b0;
        run_cycle(1'b0, 32'h0);
        check("midrst_req_count", req_addr_q.size(), 1);
        if (req_addr_q.size() > 0) check("midrst_req_addr", req_addr_q[0], 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
